// File: rtl/truth_table_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : truth_table_checker_pkg                                      |
// | Description : Shared state encoding and default sizing for the truth-table |
// |               sweep-and-compare engine.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package truth_table_checker_pkg;

   // Default number of DUT inputs and settle cycles per vector
   localparam int TT_N_IN   = 3;
   localparam int TT_SETTLE = 1;

   // Sweep controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/truth_table_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : truth_table_checker_if                                       |
// | Description : Stimulus/response bundle between the sweep engine and the    |
// |               pair of expression modules it compares.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface truth_table_checker_if #(
   parameter int N_IN = truth_table_checker_pkg::TT_N_IN
);
   logic                 start;
   logic [N_IN-1:0]      vec_out;
   logic                 a_in;
   logic                 b_in;
   logic                 busy;
   logic                 done;
   logic                 equal;
   logic [N_IN:0]        mismatch_count;
   logic [N_IN-1:0]      first_bad;
   logic                 first_bad_vld;
   logic [2**N_IN-1:0]   table_a;
   logic [2**N_IN-1:0]   table_b;

   // Requester side: launches sweeps and hosts the two expressions under test
   modport master (
      output start, a_in, b_in,
      input  vec_out, busy, done, equal, mismatch_count,
             first_bad, first_bad_vld, table_a, table_b
   );

   // Checker side
   modport slave (
      input  start, a_in, b_in,
      output vec_out, busy, done, equal, mismatch_count,
             first_bad, first_bad_vld, table_a, table_b
   );
endinterface
`default_nettype wire

// File: rtl/truth_table_checker_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : truth_table_checker_settle_timer                             |
// | Description : Down-counter giving the expression pair SETTLE cycles to     |
// |               respond to a new vector before it is sampled.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module truth_table_checker_settle_timer #(
   parameter int SETTLE = truth_table_checker_pkg::TT_SETTLE
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic load_i,
   output logic      expire_o
);
   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Reload while the vector is being applied, then count down to zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(SETTLE);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Last waiting cycle: the controller moves to sampling on this edge
   assign expire_o = (cnt_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : truth_table_checker                                          |
// | Description : Sweeps every input vector onto an expression pair, captures  |
// |               both outputs as truth tables and reports equivalence,        |
// |               mismatch count and the lowest mismatching vector.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module truth_table_checker
   import truth_table_checker_pkg::*;
#(
   parameter int N_IN   = TT_N_IN,
   parameter int SETTLE = TT_SETTLE
) (
   input  wire logic             clk,
   input  wire logic             reset,
   truth_table_checker_if.slave  bus
);
   localparam int              NV      = 2**N_IN;
   localparam int              CW      = N_IN + 1;
   localparam logic [N_IN-1:0] VEC_MAX = '1;

   state_t            state_q;
   logic [N_IN-1:0]   vec_q;
   logic              busy_q;
   logic              done_q;
   logic              equal_q;
   logic [CW-1:0]     count_q;
   logic [N_IN-1:0]   fb_q;
   logic              fbv_q;
   logic [NV-1:0]     ta_q;
   logic [NV-1:0]     tb_q;

   logic [NV-1:0]     ta_d;
   logic [NV-1:0]     tb_d;
   logic              miss_d;
   logic              expire_w;

   generate
      if (SETTLE > 0) begin : g_settle
         truth_table_checker_settle_timer #(
            .SETTLE (SETTLE)
         ) u_timer (
            .clk      (clk),
            .reset    (reset),
            .load_i   (state_q == ST_APPLY),
            .expire_o (expire_w)
         );
      end else begin : g_no_settle
         // APPLY goes straight to SAMPLE, so WAIT is never entered
         assign expire_w = 1'b0;
      end
   endgenerate

   // Tables as they will look once the current vector is captured; equal
   // is judged on these so the final vector counts toward it
   always_comb begin
      ta_d         = ta_q;
      tb_d         = tb_q;
      ta_d[vec_q]  = bus.a_in;
      tb_d[vec_q]  = bus.b_in;
      miss_d       = bus.a_in ^ bus.b_in;
   end

   // Sweep controller with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         equal_q <= 1'b0;
         count_q <= '0;
         fb_q    <= '0;
         fbv_q   <= 1'b0;
         ta_q    <= '0;
         tb_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q <= ST_APPLY;
                  vec_q   <= '0;
                  busy_q  <= 1'b1;
                  equal_q <= 1'b0;
                  count_q <= '0;
                  fb_q    <= '0;
                  fbv_q   <= 1'b0;
                  ta_q    <= '0;
                  tb_q    <= '0;
               end
            end
            ST_APPLY: begin
               state_q <= (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
            end
            ST_WAIT: begin
               if (expire_w) begin
                  state_q <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               ta_q <= ta_d;
               tb_q <= tb_d;
               if (miss_d) begin
                  count_q <= count_q + CW'(1);
                  if (!fbv_q) begin
                     fb_q  <= vec_q;
                     fbv_q <= 1'b1;
                  end
               end
               // Last vector detected by compare so the counter never wraps
               if (vec_q == VEC_MAX) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  equal_q <= (ta_d == tb_d);
               end else begin
                  vec_q   <= vec_q + N_IN'(1);
                  state_q <= ST_APPLY;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.vec_out        = vec_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.equal          = equal_q;
   assign bus.mismatch_count = count_q;
   assign bus.first_bad      = fb_q;
   assign bus.first_bad_vld  = fbv_q;
   assign bus.table_a        = ta_q;
   assign bus.table_b        = tb_q;

endmodule
`default_nettype wire
